// File: rtl/reg_file_pipe.sv
// Parametrised register file with pipelined primary/aux write ports, busy scoreboard and fixed taps.
// Optional read bypass of pending writes on rd_data_a/b when REGFILE_BYPASS_EN is defined.
module reg_file_pipe #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int WR_LAT   = 1,
  parameter int AUX_IDX  = 10,
  parameter int CTRL_IDX = 11,
  parameter int MEM_IDX  = 9,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   aux_wr_en,
  input  logic [WIDTH-1:0]       aux_wr_data,
  input  logic [AW-1:0]          rd_addr_a,
  output logic [WIDTH-1:0]       rd_data_a,
  input  logic [AW-1:0]          rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic [WIDTH-1:0]       ctrl,
  output logic [WIDTH-1:0]       memd_top,
  output logic [DEPTH-1:0]       busy,
  output logic [WIDTH*DEPTH-1:0] q
);

  // WR_LAT=0 still keeps one (permanently empty) stage so busy/bypass logic stays uniform.
  localparam int PL = (WR_LAT == 0) ? 1 : WR_LAT;

  typedef struct packed {
    logic             v;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_entry_t;

  logic [WIDTH-1:0] regs [DEPTH];
  wr_entry_t        pri_acc, aux_acc, pri_commit, aux_commit;
  wr_entry_t        pri_pipe [PL];
  wr_entry_t        aux_pipe [PL];

  // Out-of-range primary writes are never accepted, so they can neither commit nor set busy.
  assign pri_acc = '{v: !rst && wr_en && (int'(wr_addr) < DEPTH), addr: wr_addr, data: wr_data};
  assign aux_acc = '{v: !rst && aux_wr_en, addr: AW'(AUX_IDX), data: aux_wr_data};

  generate
    if (WR_LAT == 0) begin : g_direct
      assign pri_pipe[0] = '0;
      assign aux_pipe[0] = '0;
      assign pri_commit  = pri_acc;
      assign aux_commit  = aux_acc;
    end else begin : g_pipe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < PL; s++) begin
            pri_pipe[s] <= '0;
            aux_pipe[s] <= '0;
          end
        end else begin
          pri_pipe[0] <= pri_acc;
          aux_pipe[0] <= aux_acc;
          for (int s = 1; s < PL; s++) begin
            pri_pipe[s] <= pri_pipe[s-1];
            aux_pipe[s] <= aux_pipe[s-1];
          end
        end
      end
      assign pri_commit = pri_pipe[PL-1];
      assign aux_commit = aux_pipe[PL-1];
    end
  endgenerate

  // NOTE: the storage array is reset explicitly because every register must read 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (pri_commit.v) regs[pri_commit.addr] <= pri_commit.data;
      // Aux is applied second so it wins a same-edge collision on AUX_IDX.
      if (aux_commit.v) regs[aux_commit.addr] <= aux_commit.data;
    end
  end

  always_comb begin
    busy = '0;
    for (int s = 0; s < PL; s++) begin
      if (pri_pipe[s].v) busy[pri_pipe[s].addr] = 1'b1;
      if (aux_pipe[s].v) busy[aux_pipe[s].addr] = 1'b1;
    end
  end

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_val  [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = (int'(rd_addr[p]) < DEPTH) ? regs[rd_addr[p]] : '0;
`ifdef REGFILE_BYPASS_EN
      // Scan oldest to youngest so the youngest matching write is the one left standing.
      for (int s = PL - 1; s >= 0; s--) begin
        if (pri_pipe[s].v && pri_pipe[s].addr == rd_addr[p]) rd_val[p] = pri_pipe[s].data;
        if (aux_pipe[s].v && aux_pipe[s].addr == rd_addr[p]) rd_val[p] = aux_pipe[s].data;
      end
      if (pri_acc.v && pri_acc.addr == rd_addr[p]) rd_val[p] = pri_acc.data;
      if (aux_acc.v && aux_acc.addr == rd_addr[p]) rd_val[p] = aux_acc.data;
`endif
    end
  end

  assign rd_data_a = rd_val[0];
  assign rd_data_b = rd_val[1];
  assign ctrl      = regs[CTRL_IDX];
  assign memd_top  = regs[MEM_IDX];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign q[i*WIDTH +: WIDTH] = regs[i];
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_pipe.sv
// Scoreboard bench for reg_file_pipe (DEPTH=12, WR_LAT=2): per-cycle expectations from a pending-write model.
module tb_reg_file_pipe;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 12;
  localparam int WR_LAT = 2;
  localparam int AW     = 4;
  localparam int AUX    = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_en = 1'b0, aux_wr_en = 1'b0;
  logic [AW-1:0]          wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [WIDTH-1:0]       wr_data = '0, aux_wr_data = '0;
  logic [WIDTH-1:0]       rd_data_a, rd_data_b, ctrl, memd_top;
  logic [DEPTH-1:0]       busy;
  logic [WIDTH*DEPTH-1:0] q;

  reg_file_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .aux_wr_en(aux_wr_en), .aux_wr_data(aux_wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .ctrl(ctrl), .memd_top(memd_top), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    int               addr;
    logic [WIDTH-1:0] data;
  } pend_t;

  typedef struct {
    logic [WIDTH-1:0]       rda, rdb, ctrl, memd;
    logic [DEPTH-1:0]       busy;
    logic [WIDTH*DEPTH-1:0] q;
  } exp_t;

  logic [WIDTH-1:0] mregs [16];
  pend_t            pend [$];
  exp_t             exp_q [$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Clock edge in the model: retire writes whose commit cycle has come, then accept this edge's writes.
  function automatic void model_edge();
    pend_t keep [$];
    if (rst) return;
    cyc++;
    foreach (pend[k]) begin
      if (pend[k].due <= cyc) mregs[pend[k].addr] = pend[k].data;
      else keep.push_back(pend[k]);
    end
    pend = keep;
    if (wr_en && int'(wr_addr) < DEPTH) pend.push_back('{cyc + WR_LAT, int'(wr_addr), wr_data});
    if (aux_wr_en) pend.push_back('{cyc + WR_LAT, AUX, aux_wr_data});
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input int a);
    logic [WIDTH-1:0] r;
    r = (a < DEPTH) ? mregs[a] : '0;
`ifdef REGFILE_BYPASS_EN
    if (a < DEPTH && !rst) begin
      foreach (pend[k]) if (pend[k].addr == a) r = pend[k].data;
      if (wr_en && int'(wr_addr) == a) r = wr_data;
      if (aux_wr_en && a == AUX) r = aux_wr_data;
    end
`endif
    return r;
  endfunction

  task automatic step(input logic r, input logic we, input int wa, input int wd,
                      input logic ae, input int ad, input int ra, input int rb);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    rst = r;
    wr_en = we; wr_addr = AW'(wa); wr_data = WIDTH'(wd);
    aux_wr_en = ae; aux_wr_data = WIDTH'(ad);
    rd_addr_a = AW'(ra); rd_addr_b = AW'(rb);
    if (r) begin
      foreach (mregs[i]) mregs[i] = '0;
      pend.delete();
    end
    e.rda  = model_read(ra);
    e.rdb  = model_read(rb);
    e.ctrl = mregs[11];
    e.memd = mregs[9];
    e.busy = '0;
    foreach (pend[k]) e.busy[pend[k].addr] = 1'b1;
    e.q = '0;
    for (int i = 0; i < DEPTH; i++) e.q[i*WIDTH +: WIDTH] = mregs[i];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input int ra, input int rb);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, ra, rb);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data_a", 128'(rd_data_a), 128'(e.rda));
        check("rd_data_b", 128'(rd_data_b), 128'(e.rdb));
        check("ctrl",      128'(ctrl),      128'(e.ctrl));
        check("memd_top",  128'(memd_top),  128'(e.memd));
        check("busy",      128'(busy),      128'(e.busy));
        check("q",         128'(q),         128'(e.q));
      end
    end
  end

  initial begin : stimulus
    foreach (mregs[i]) mregs[i] = '0;
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);
    idle(1, 3, 3);

    step(1'b0, 1'b1, 3, 'h5A, 1'b0, 0, 3, 3);
    idle(4, 3, 0);

    step(1'b0, 1'b1, 10, 'h11, 1'b1, 'h22, 10, 10);
    idle(4, 10, 3);

    step(1'b0, 1'b1, 11, 'hC3, 1'b0, 0, 11, 9);
    step(1'b0, 1'b1, 9, 'h7E, 1'b0, 0, 11, 9);
    idle(4, 11, 9);

    step(1'b0, 1'b1, 5, 'h01, 1'b0, 0, 5, 5);
    step(1'b0, 1'b1, 5, 'h02, 1'b0, 0, 5, 5);
    step(1'b0, 1'b1, 5, 'h03, 1'b0, 0, 5, 5);
    idle(5, 5, 13);

    step(1'b0, 1'b1, 13, 'hFF, 1'b0, 0, 13, 13);
    idle(4, 13, 12);

    step(1'b0, 1'b1, 1, 'hAA, 1'b1, 'hBB, 1, 10);
    step(1'b0, 1'b1, 2, 'hCC, 1'b0, 0, 2, 10);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 2);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, 1, 2);
    idle(5, 1, 2);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    idle(4, 10, 11);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
